// File: rtl/board_switch_sword.sv
// rtl/board_switch_sword.sv - periodic 74HC165-chain reader with two-scan debounce
// Loads the external PISO chain every COUNT_SCAN cycles, shifts DATA_BITS in, accepts on two matching scans.
module board_switch_sword #(
  parameter int CLK_FREQ    = 100,
  parameter int S_CLK_FREQ  = 25,
  parameter int DATA_BITS   = 16,
  parameter int SCAN_US     = 10000,
  parameter int CODE_ENDIAN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 s_clk,
  output logic                 s_load_n,
  input  logic                 s_di,
  output logic [DATA_BITS-1:0] data,
  output logic                 update,
  output logic                 busy
);

  localparam int HALF       = CLK_FREQ / (2 * S_CLK_FREQ);
  localparam int COUNT_SCAN = CLK_FREQ * SCAN_US;
  localparam int CW         = (COUNT_SCAN > 2) ? $clog2(COUNT_SCAN) : 1;
  localparam int PW         = (HALF > 2) ? $clog2(HALF) : 1;
  localparam int KW         = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KW-1:0]        pos;
  logic [DATA_BITS-1:0] shbuf_q, shbuf_d;
  logic [DATA_BITS-1:0] prev_q, prev_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 update_q, update_d;
  logic                 s_clk_q, s_clk_d;
  logic                 s_load_n_q, s_load_n_d;
  logic                 busy_q, busy_d;
  logic                 s_di_q;
  logic                 cnt_wrap;
  logic                 ph_last;

  always_comb begin
    cnt_wrap = (cnt_q == CW'(COUNT_SCAN - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    ph_last  = (ph_q == PW'(HALF - 1));
    pos      = (CODE_ENDIAN != 0) ? (KW'(DATA_BITS - 1) - k_q) : k_q;

    state_d  = state_q;
    ph_d     = ph_q;
    k_d      = k_q;
    shbuf_d  = shbuf_q;
    prev_d   = prev_q;
    data_d   = data_q;
    update_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Counter wraps seen outside IDLE are simply dropped.
        if (cnt_wrap) begin
          state_d = LOAD;
          ph_d    = '0;
        end
      end
      LOAD: begin
        if (ph_last) begin
          state_d = SHIFT_LO;
          ph_d    = '0;
          k_d     = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      SHIFT_LO: begin
        if (ph_last) begin
          shbuf_d[pos] = s_di_q;
          state_d      = SHIFT_HI;
          ph_d         = '0;
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (ph_last) begin
          ph_d = '0;
          if (k_q == KW'(DATA_BITS - 1)) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      DONE: begin
        prev_d = shbuf_q;
        if ((shbuf_q == prev_q) && (shbuf_q != data_q)) begin
          data_d   = shbuf_q;
          update_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pin drivers are registered from the next state so they stay glitch-free and aligned with state_q.
    s_clk_d    = (state_d == SHIFT_HI);
    s_load_n_d = (state_d != LOAD);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    s_di_q <= s_di;
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ph_q       <= '0;
      k_q        <= '0;
      shbuf_q    <= '0;
      prev_q     <= '0;
      data_q     <= '0;
      update_q   <= 1'b0;
      s_clk_q    <= 1'b0;
      s_load_n_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      k_q        <= k_d;
      shbuf_q    <= shbuf_d;
      prev_q     <= prev_d;
      data_q     <= data_d;
      update_q   <= update_d;
      s_clk_q    <= s_clk_d;
      s_load_n_q <= s_load_n_d;
      busy_q     <= busy_d;
    end
  end

  assign s_clk    = s_clk_q;
  assign s_load_n = s_load_n_q;
  assign data     = data_q;
  assign update   = update_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_board_switch_sword.sv
// tb/tb_board_switch_sword.sv - directed bench for board_switch_sword with a 74HC165 chain model
// Two instances (MSB-first and LSB-first placement) share one chain; the chain follows instance a's pins.
module tb_board_switch_sword;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_di;
  logic        s_clk_a, s_load_n_a, update_a, busy_a;
  logic        s_clk_b, s_load_n_b, update_b, busy_b;
  logic [15:0] data_a, data_b;

  logic [15:0] chain_val;
  logic [15:0] sr = '0;
  logic        sclk_last = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          last_start = 0;

  always #5 clk = ~clk;

  board_switch_sword #(.SCAN_US(2), .CODE_ENDIAN(1)) u_dut_a (
    .clk(clk), .rst(rst), .s_clk(s_clk_a), .s_load_n(s_load_n_a), .s_di(s_di),
    .data(data_a), .update(update_a), .busy(busy_a)
  );

  board_switch_sword #(.SCAN_US(2), .CODE_ENDIAN(0)) u_dut_b (
    .clk(clk), .rst(rst), .s_clk(s_clk_b), .s_load_n(s_load_n_b), .s_di(s_di),
    .data(data_b), .update(update_b), .busy(busy_b)
  );

  // Chain: parallel load while s_load_n is low, shift toward QH after each s_clk rise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!s_load_n_a) sr <= chain_val;
    else if (s_clk_a && !sclk_last) sr <= {sr[14:0], 1'b0};
    sclk_last <= s_clk_a;
  end
  assign s_di = sr[15];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(output int lat, output int act);
    lat = 0;
    act = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy_a && (s_clk_a || !s_load_n_a)) act++;
    end while (!busy_a && lat < 400);
  endtask

  task automatic do_scan(output int edges, output int busy_n, output int load_n,
                         output int upd_n, output int viol, output int period);
    int lat, act;
    logic prev_sclk;
    edges = 0; busy_n = 0; load_n = 0; upd_n = 0; viol = 0;
    if (!busy_a) wait_busy(lat, act);
    check_eq("scan_started", busy_a, 1'b1);
    period = cyc - last_start;
    last_start = cyc;
    prev_sclk = 1'b0;
    while (busy_a && busy_n < 400) begin
      busy_n++;
      if (!s_load_n_a) load_n++;
      if (s_clk_a && !prev_sclk) edges++;
      if (s_clk_a && !s_load_n_a) viol++;
      if (update_a) upd_n++;
      prev_sclk = s_clk_a;
      @(negedge clk);
    end
    repeat (3) begin
      if (update_a) upd_n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, act, e, bn, ln, un, vi, per, rises, usum;
    logic [15:0] pat [4];
    pat = '{16'h00FF, 16'h00FE, 16'h00FF, 16'h00FE};

    rst = 1'b1;
    chain_val = 16'hA5C3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_s_clk", s_clk_a, 1'b0);
    check_eq("rst_s_load_n", s_load_n_a, 1'b1);
    check_eq("rst_data", data_a, 16'h0000);
    check_eq("rst_update", update_a, 1'b0);
    check_eq("rst_busy", busy_a, 1'b0);
    rst = 1'b0;

    wait_busy(lat, act);
    check_eq("first_start_latency", lat, 200);
    check_eq("quiet_before_first_scan", act, 0);
    last_start = cyc;

    do_scan(e, bn, ln, un, vi, per);
    check_eq("s1_edges", e, 16);
    check_eq("s1_busy_cycles", bn, 67);
    check_eq("s1_load_cycles", ln, 2);
    check_eq("s1_sclk_during_load", vi, 0);
    check_eq("s1_updates", un, 0);
    check_eq("s1_data", data_a, 16'h0000);

    do_scan(e, bn, ln, un, vi, per);
    check_eq("s2_period", per, 200);
    check_eq("s2_edges", e, 16);
    check_eq("s2_updates", un, 1);
    check_eq("s2_data_msb_first", data_a, 16'hA5C3);
    check_eq("s2_data_lsb_first", data_b, 16'hC3A5);

    do_scan(e, bn, ln, un, vi, per);
    check_eq("s3_period", per, 200);
    check_eq("s3_updates", un, 0);
    check_eq("s3_data", data_a, 16'hA5C3);

    // Abort during the 8th high phase of s_clk.
    wait_busy(lat, act);
    rises = 0;
    begin
      logic ps;
      ps = 1'b0;
      while (rises < 8 && busy_a) begin
        if (s_clk_a && !ps) rises++;
        ps = s_clk_a;
        if (rises < 8) @(negedge clk);
      end
    end
    check_eq("mid_reached_8th_hi", rises, 8);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_s_clk", s_clk_a, 1'b0);
    check_eq("mid_s_load_n", s_load_n_a, 1'b1);
    check_eq("mid_busy", busy_a, 1'b0);
    check_eq("mid_data", data_a, 16'h0000);
    check_eq("mid_update", update_a, 1'b0);
    rst = 1'b0;
    wait_busy(lat, act);
    check_eq("mid_restart_latency", lat, 200);
    check_eq("mid_quiet", act, 0);
    last_start = cyc;
    do_scan(e, bn, ln, un, vi, per);
    check_eq("mid_s1_updates", un, 0);
    check_eq("mid_s1_data", data_a, 16'h0000);
    do_scan(e, bn, ln, un, vi, per);
    check_eq("mid_s2_updates", un, 1);
    check_eq("mid_s2_data", data_a, 16'hA5C3);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_start = cyc;
    for (int i = 0; i < 4; i++) begin
      chain_val = pat[i];
      do_scan(e, bn, ln, un, vi, per);
      check_eq("bounce_updates", un, 0);
      check_eq("bounce_data", data_a, 16'h0000);
    end
    chain_val = 16'h00FE;
    usum = 0;
    for (int i = 0; i < 2; i++) begin
      do_scan(e, bn, ln, un, vi, per);
      usum += un;
    end
    check_eq("settle_updates", usum, 1);
    check_eq("settle_data", data_a, 16'h00FE);
    check_eq("settle_data_lsb_first", data_b, 16'h7F00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
